// File: rtl/hex_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared decoder, NUM_DIGITS common-anode digits,
// double-buffered display value committed at frame boundaries, guard gaps, leading-zero blanking.
module hex_scan_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int DWELL      = 50000,
  parameter int GUARD      = 500
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      blank_lz,
  input  logic                      load_valid,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  output logic                      load_ready,
  output logic [3:0]                hexnum,
  output logic [NUM_DIGITS-1:0]     digit_sel_n,
  output logic                      frame_start
);
  localparam int MAXC = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DIGITS);

  typedef enum logic {S_GUARD, S_SHOW} state_t;

  state_t                        state, state_n;
  logic [CW-1:0]                 cnt, cnt_n;
  logic [IW-1:0]                 idx, idx_n;
  logic                          first, first_n;
  logic [NUM_DIGITS-1:0][3:0]    disp, disp_n, pbuf, pbuf_n;
  logic                          pend, pend_n;
  logic                          bound;
  logic [NUM_DIGITS:0]           zero_up;
  logic                          blanked;
  logic [NUM_DIGITS-1:0]         sel_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    first_n = first;
    bound   = 1'b0;
    if (!enable) begin
      state_n = S_GUARD;
      cnt_n   = '0;
      idx_n   = '0;
      first_n = 1'b1;
    end else begin
      case (state)
        S_GUARD: begin
          if (cnt == CW'(GUARD - 1)) begin
            state_n = S_SHOW;
            cnt_n   = '0;
            first_n = 1'b0;
            // first exit after reset/disable stays on digit 0
            if (first || idx == IW'(NUM_DIGITS - 1)) idx_n = '0;
            else                                     idx_n = idx + IW'(1);
            bound = (idx_n == '0);
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == CW'(DWELL - 1)) begin
            state_n = S_GUARD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    disp_n = disp;
    pbuf_n = pbuf;
    pend_n = pend;
    if (bound && pend) begin
      disp_n = pbuf;
      pend_n = 1'b0;
    end else if (load_valid && load_ready) begin
      pbuf_n = load_data;
      pend_n = 1'b1;
    end
  end

  // digit i is a leading zero when it and every higher nibble are zero
  always_comb begin
    zero_up[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      zero_up[i] = zero_up[i+1] && (disp_n[i] == 4'h0);
    blanked = blank_lz && (idx_n != '0) && zero_up[idx_n];
    sel_n   = '1;
    if (state_n == S_SHOW && !blanked) sel_n[idx_n] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_GUARD;
      cnt         <= '0;
      idx         <= '0;
      first       <= 1'b1;
      disp        <= '0;
      pbuf        <= '0;
      pend        <= 1'b0;
      load_ready  <= 1'b1;
      hexnum      <= 4'h0;
      digit_sel_n <= '1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      first       <= first_n;
      disp        <= disp_n;
      pbuf        <= pbuf_n;
      pend        <= pend_n;
      load_ready  <= ~pend_n;
      hexnum      <= disp_n[idx_n];
      digit_sel_n <= sel_n;
      frame_start <= bound;
    end
  end
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with NUM_DIGITS=4, DWELL=4, GUARD=2 (24-cycle frames).
module tb_hex_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, enable, blank_lz, load_valid;
  logic [15:0] load_data;
  logic        load_ready, frame_start;
  logic [3:0]  hexnum, digit_sel_n;
  int          ntests = 0;
  int          nfail  = 0;

  hex_scan_ctrl #(.NUM_DIGITS(4), .DWELL(4), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .blank_lz(blank_lz),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .hexnum(hexnum), .digit_sel_n(digit_sel_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // frame layout: S0 x4, G x2, S1 x4, G x2, S2 x4, G x2, S3 x4, G x2
  task automatic cyc(input int p, input logic [15:0] val, input bit blz);
    int d, q;
    logic [3:0] nib, esel;
    d   = p / 6;
    q   = p % 6;
    nib = 4'((val >> (4 * d)) & 16'hF);
    if (q < 4) begin
      esel = 4'hF;
      if (!(blz && d > 0 && (val >> (4 * d)) == 16'h0)) esel[d] = 1'b0;
      chk($sformatf("sel p%0d", p), digit_sel_n, esel);
      chk($sformatf("hex p%0d", p), hexnum, nib);
    end else begin
      chk($sformatf("sel p%0d", p), digit_sel_n, 4'hF);
    end
    chk($sformatf("fs p%0d", p), frame_start, (p == 0));
  endtask

  task automatic act(input int fid, input int p);
    case (fid)
      0: begin
        if (p == 5) begin load_valid = 1'b1; load_data = 16'h1234; end
        if (p == 6) begin chk("ld_drop", load_ready, 0); load_data = 16'h5678; end
        if (p == 23) begin chk("ld_held", load_ready, 0); load_data = 16'hAAAA; end
      end
      1: begin
        if (p == 0) begin chk("rdy_commit", load_ready, 1); load_data = 16'h5678; end
        if (p == 1) begin chk("ld2_acc", load_ready, 0); load_valid = 1'b0; end
      end
      2: begin
        if (p == 0) chk("rdy_c2", load_ready, 1);
        if (p == 2) begin blank_lz = 1'b1; load_valid = 1'b1; load_data = 16'h0050; end
        if (p == 3) begin load_valid = 1'b0; chk("ld3_acc", load_ready, 0); end
      end
      3: begin
        if (p == 2) begin load_valid = 1'b1; load_data = 16'h0000; end
        if (p == 3) load_valid = 1'b0;
      end
      4: if (p == 23) blank_lz = 1'b0;
      6: begin
        if (p == 2) begin load_valid = 1'b1; load_data = 16'h9999; end
        if (p == 3) begin
          load_valid = 1'b0;
          #2 rst_n = 1'b0;
          #1;
          chk("arst_sel", digit_sel_n, 4'hF);
          chk("arst_rdy", load_ready, 1);
          chk("arst_hex", hexnum, 0);
          chk("arst_fs", frame_start, 0);
        end
      end
      default: ;
    endcase
  endtask

  task automatic frame(input int fid, input logic [15:0] val, input bit blz, input int last_p);
    for (int p = 0; p <= last_p; p++) begin
      step();
      cyc(p, val, blz);
      act(fid, p);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; blank_lz = 1'b0; load_valid = 1'b0; load_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_sel", digit_sel_n, 4'hF);
    chk("rst_hex", hexnum, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_rdy", load_ready, 1);

    rst_n = 1'b1; enable = 1'b1;
    step();
    chk("g0_sel", digit_sel_n, 4'hF);
    frame(0, 16'h0000, 1'b0, 23);
    frame(1, 16'h1234, 1'b0, 23);
    frame(2, 16'h5678, 1'b0, 23);
    frame(3, 16'h0050, 1'b1, 23);
    frame(4, 16'h0000, 1'b1, 23);
    frame(5, 16'h0000, 1'b0, 13);

    enable = 1'b0;
    step();
    chk("dis_sel", digit_sel_n, 4'hF);
    chk("dis_fs", frame_start, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("dis_sel%0d", i), digit_sel_n, 4'hF);
    end
    enable = 1'b1;
    step();
    chk("reen_g", digit_sel_n, 4'hF);
    frame(6, 16'h0000, 1'b0, 3);

    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_g", digit_sel_n, 4'hF);
    frame(7, 16'h0000, 1'b0, 23);
    chk("post_rst_rdy", load_ready, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
